// File: rtl/fifo_rd_packer.sv
// Read-domain drain stage: pops narrow FIFO words, packs RATIO lanes little-endian into a wide
// word, and presents it through a 2-entry registered valid/ready queue with flush support.
module fifo_rd_packer #(
  parameter int D_SIZE = 8,
  parameter int RATIO  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_fifo_empty,
  input  logic [D_SIZE-1:0]         i_fifo_data,
  output logic                      o_fifo_inc,
  input  logic                      i_flush,
  output logic                      o_flush_done,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [D_SIZE*RATIO-1:0]   o_data,
  output logic [RATIO-1:0]          o_keep,
  output logic                      o_last
);

  localparam int W  = D_SIZE * RATIO;
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [D_SIZE-1:0] acc_q [RATIO-1];
  logic [D_SIZE-1:0] acc_d [RATIO-1];
  logic [1:0]        qc_q, qc_d;
  logic              flush_pending_q, flush_pending_d;
  logic              flush_done_q, flush_done_d;
  logic [W-1:0]      head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [RATIO-1:0]  head_keep_q, head_keep_d, tail_keep_q, tail_keep_d;
  logic              head_last_q, head_last_d, tail_last_q, tail_last_d;

  logic              space_s, fifo_inc_s, flush_fire_s, qpop_s;
  logic              push_s, push_last_s;
  logic [W-1:0]      push_data_s;
  logic [RATIO-1:0]  push_keep_s;

  assign o_fifo_inc   = fifo_inc_s & ~i_rst;
  assign o_flush_done = flush_done_q;
  assign o_valid      = (qc_q != 2'd0);
  assign o_data       = head_data_q;
  assign o_keep       = head_keep_q;
  assign o_last       = head_last_q;

  // Pop decision, word assembly and packer next state
  always_comb begin
    space_s      = (qc_q != 2'd2);
    fifo_inc_s   = ~i_fifo_empty & ~flush_pending_q & ((cnt_q != CNT_LAST) | space_s);
    flush_fire_s = flush_pending_q & space_s;
    qpop_s       = (qc_q != 2'd0) & i_ready;
    push_s       = 1'b0;
    push_data_s  = '0;
    push_keep_s  = '0;
    push_last_s  = 1'b0;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    flush_pending_d = flush_pending_q;
    flush_done_d = flush_fire_s;

    if (fifo_inc_s && (cnt_q == CNT_LAST)) begin
      push_s = 1'b1;
      for (int k = 0; k < RATIO - 1; k++) push_data_s[k*D_SIZE +: D_SIZE] = acc_q[k];
      push_data_s[(RATIO-1)*D_SIZE +: D_SIZE] = i_fifo_data;
      push_keep_s = '1;
    end else if (flush_fire_s && (cnt_q != '0)) begin
      // Lanes at or above cnt are stale and must leave as zero
      push_s      = 1'b1;
      push_last_s = 1'b1;
      for (int k = 0; k < RATIO - 1; k++) begin
        if (k < int'(cnt_q)) begin
          push_data_s[k*D_SIZE +: D_SIZE] = acc_q[k];
          push_keep_s[k] = 1'b1;
        end else begin
          push_data_s[k*D_SIZE +: D_SIZE] = '0;
          push_keep_s[k] = 1'b0;
        end
      end
    end else begin
      push_s = 1'b0;
    end

    if (fifo_inc_s) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      for (int k = 0; k < RATIO - 1; k++) begin
        if (cnt_q == CW'(k)) acc_d[k] = i_fifo_data;
      end
    end else if (flush_fire_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q;
    end

    if (flush_fire_s) begin
      flush_pending_d = 1'b0;
    end else if (i_flush) begin
      flush_pending_d = 1'b1;
    end else begin
      flush_pending_d = flush_pending_q;
    end
  end

  // Two-entry output queue; the head registers drive the outputs directly
  always_comb begin
    qc_d        = qc_q;
    head_data_d = head_data_q;
    head_keep_d = head_keep_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_keep_d = tail_keep_q;
    tail_last_d = tail_last_q;
    case (qc_q)
      2'd0: begin
        if (push_s) begin
          head_data_d = push_data_s;
          head_keep_d = push_keep_s;
          head_last_d = push_last_s;
          qc_d        = 2'd1;
        end else begin
          qc_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && qpop_s) begin
          head_data_d = push_data_s;
          head_keep_d = push_keep_s;
          head_last_d = push_last_s;
        end else if (push_s) begin
          tail_data_d = push_data_s;
          tail_keep_d = push_keep_s;
          tail_last_d = push_last_s;
          qc_d        = 2'd2;
        end else if (qpop_s) begin
          head_data_d = '0;
          head_keep_d = '0;
          head_last_d = 1'b0;
          qc_d        = 2'd0;
        end else begin
          qc_d = 2'd1;
        end
      end
      2'd2: begin
        if (qpop_s) begin
          head_data_d = tail_data_q;
          head_keep_d = tail_keep_q;
          head_last_d = tail_last_q;
          qc_d        = 2'd1;
        end else begin
          qc_d = 2'd2;
        end
      end
      default: begin
        qc_d = 2'd0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q           <= '0;
      for (int k = 0; k < RATIO - 1; k++) acc_q[k] <= '0;
      qc_q            <= 2'd0;
      flush_pending_q <= 1'b0;
      flush_done_q    <= 1'b0;
      head_data_q     <= '0;
      head_keep_q     <= '0;
      head_last_q     <= 1'b0;
      tail_data_q     <= '0;
      tail_keep_q     <= '0;
      tail_last_q     <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      acc_q           <= acc_d;
      qc_q            <= qc_d;
      flush_pending_q <= flush_pending_d;
      flush_done_q    <= flush_done_d;
      head_data_q     <= head_data_d;
      head_keep_q     <= head_keep_d;
      head_last_q     <= head_last_d;
      tail_data_q     <= tail_data_d;
      tail_keep_q     <= tail_keep_d;
      tail_last_q     <= tail_last_d;
    end
  end

endmodule
